stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control and timebase stage feeding the stopwatch digit-counter chain. Conditions the start/stop and clear push-buttons, runs an IDLE/RUN/PAUSE state machine, and divides `clk` into a single-cycle `tick` that drives the enable of the least-significant digit counter. It also issues a one-cycle `clr` pulse that zeroes the whole chain.

## Interface
- `TICK_DIV`, default 1_000_000: `clk` cycles per `tick` (100 MHz → 100 Hz); legal range ≥ 2.
- `DB_CYCLES`, default 1_000_000: stable-input cycles required by the debouncer; legal range ≥ 2.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `btn_start`, input, 1: raw start/stop button, asynchronous, high = pressed.
- `btn_clear`, input, 1: raw clear button, asynchronous, high = pressed.
- `tick`, output, 1: one-cycle pulse, enable to the first digit counter.
- `clr`, output, 1: one-cycle pulse, synchronous clear to all digit counters.
- `running`, output, 1: high while the state is RUN.
- `state`, output, 2: current state (IDLE=0, RUN=1, PAUSE=2; 3 is unused).

## Operation
- Each button passes through a 2-FF synchronizer and then a rising-edge detector. The result is a one-cycle press pulse: `start_p` or `clear_p`.
- State transitions:
  - IDLE: `start_p` → RUN.
  - RUN: `start_p` → PAUSE.
  - PAUSE: `start_p` → RUN.
  - `clear_p` in any state → IDLE, with `clr`=1 for one cycle. This includes IDLE, which stays in IDLE.
  - If `start_p` and `clear_p` are high in the same cycle, clear wins.
- Prescaler `div_cnt`, width `$clog2(TICK_DIV)`:
  - Increments on every clock while in RUN.
  - When `div_cnt == TICK_DIV-1` in RUN: wraps to 0 and registers `tick`=1 for one cycle.
  - Holds its value in PAUSE, so fractional time is preserved across pause/resume.
  - Forced to 0 whenever `clr` is issued.
- `tick` is never asserted outside RUN, and never in the same cycle as `clr`.
- A held button produces exactly one press pulse. The next press pulse requires a release first.
- Reset values: state=IDLE, `div_cnt`=0, `tick`=0, `clr`=0, `running`=0. All synchronizer and edge registers reset to 0 (button released).
- A reset asserted mid-count returns the block to IDLE immediately. No `clr` pulse is produced by reset; the counters take `reset` directly.

## Timing
- Button rise to press pulse:
  - Without debounce: 3 cycles (sync 2 + edge register 1).
  - With debounce: `DB_CYCLES` + 3 cycles.
- Press pulse at cycle n → `state`/`running` update at cycle n+1; `clr` is high during cycle n+1.
- First `tick` after entering RUN from IDLE: `TICK_DIV` cycles after `running` rises. Thereafter one tick every `TICK_DIV` cycles.
- Resume from PAUSE: the first tick arrives `TICK_DIV - div_cnt_held` cycles after `running` rises.
- `tick`, `clr`, `running` and `state` are all registered outputs; none has a combinational path from the inputs.

## Configuration
- Macro: `STOPWATCH_CTRL_DEBOUNCE_EN`.
- Defined:
  - A debouncer sits between the synchronizer and the edge detector.
  - The debounced level flips only after the synchronized input differs from it for `DB_CYCLES` consecutive cycles; any bounce restarts that count.
  - Edge detection operates on the debounced level.
- Undefined:
  - The debouncer and its counter are omitted and `DB_CYCLES` is ignored.
  - Edge detection operates directly on the synchronized input; intended for simulation and for pre-debounced inputs.

## Structure
- Shared package `stopwatch_pkg` holds:
  - The state enum type (`SW_IDLE`, `SW_RUN`, `SW_PAUSE`; 2 bits).
  - Default constants `TICK_DIV_DEFAULT` and `DB_CYCLES_DEFAULT`.
- Sub-module `btn_conditioner`, instantiated twice (once per button):
  - Contains the synchronizer, the optional debouncer and the edge detector.
  - Port: `pressed`, a one-cycle pulse.
- The FSM and prescaler live in `stopwatch_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4, `DB_CYCLES`=3 and the macro defined unless noted.
- Reset then start: release reset, hold `btn_start` high 10 cycles → one press; `running` rises at cycle 7; ticks at cycles 11, 15, 19 (relative to button rise); never two consecutive ticks.
- Pause/resume: press start at `div_cnt`=2 → `running` falls, no further tick; press again → first tick 2 cycles after `running` rises.
- Clear while running: press clear mid-count → one `clr` pulse, state=IDLE, `div_cnt`=0; the next start gives its first tick exactly 4 cycles after `running` rises.
- Simultaneous start and clear: raise both buttons in the same cycle → `clr`=1, state=IDLE, `running` stays 0.
- Bounce rejection: toggle `btn_start` every 2 cycles for 20 cycles, then hold high → exactly one press pulse, 6 cycles after the final rise.
- Reset mid-operation and macro undefined: assert `reset` during RUN → all outputs 0 in the same cycle, no `clr`. Rebuild without the macro: press latency 3 cycles, a 1-cycle glitch produces a press.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control/timebase stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam int TICK_DIV_DEFAULT  = 1_000_000;
  localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, optional debouncer
// (STOPWATCH_CTRL_DEBOUNCE_EN) and rising-edge detector giving a one-cycle press.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pressed
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn};
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt;

  // Level follows the synchronized input only after DB_CYCLES consecutive
  // disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_q[1] == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      level  <= sync_q[1];
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  logic unused_db_cycles;
  assign unused_db_cycles = (DB_CYCLES < 2);
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pressed <= 1'b0;
    end else begin
      level_q <= level;
      pressed <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timebase: IDLE/RUN/PAUSE FSM plus tick prescaler.
// Button debouncing is enabled by defining STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic             start_p;
  logic             clear_p;
  sw_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic             tick_d, clr_d;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_start),
    .pressed (start_p)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_clear),
    .pressed (clear_p)
  );

  // Clear has priority; the prescaler only advances on cycles that stay in
  // RUN, so a pause freezes the fractional count exactly.
  always_comb begin
    state_d = state_q;
    div_d   = div_cnt;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    if (clear_p) begin
      state_d = SW_IDLE;
      div_d   = '0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        SW_IDLE:  if (start_p) state_d = SW_RUN;
        SW_RUN: begin
          if (start_p) begin
            state_d = SW_PAUSE;
          end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
            div_d  = '0;
            tick_d = 1'b1;
          end else begin
            div_d = div_cnt + 1'b1;
          end
        end
        SW_PAUSE: if (start_p) state_d = SW_RUN;
        default:  state_d = SW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SW_IDLE;
      div_cnt <= '0;
      tick    <= 1'b0;
      clr     <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt <= div_d;
      tick    <= tick_d;
      clr     <= clr_d;
      running <= (state_d == SW_RUN);
    end
  end

  assign state = state_q;

endmodule
